// File: rtl/sad_mem_resp_if.sv
// rtl/sad_mem_resp_if.sv - bus bundle between the SAD engine/host and sad_mem_resp
//
// Purpose : groups every non-clock, non-reset signal of sad_mem_resp.
// Ports   : input-memory read port (I_En, I_RW, A_Addr, B_Addr -> A_Data, B_Data),
//           result write port (O_En, O_RW, C_Addr, SAD_In),
//           host preload port (Ld_En, Ld_Sel, Ld_Addr, Ld_Data),
//           host readback port (Rd_En, Rd_Addr -> Rd_Data, Rd_Valid),
//           status (Wr_Count, Coll_Err).
// Modports: master drives requests, slave is the memory block.
interface sad_mem_resp_if;
  logic        I_En;
  logic        I_RW;
  logic [14:0] A_Addr;
  logic [14:0] B_Addr;
  logic [7:0]  A_Data;
  logic [7:0]  B_Data;
  logic        O_En;
  logic        O_RW;
  logic [6:0]  C_Addr;
  logic [31:0] SAD_In;
  logic        Ld_En;
  logic        Ld_Sel;
  logic [14:0] Ld_Addr;
  logic [7:0]  Ld_Data;
  logic        Rd_En;
  logic [6:0]  Rd_Addr;
  logic [31:0] Rd_Data;
  logic        Rd_Valid;
  logic [7:0]  Wr_Count;
  logic        Coll_Err;

  modport master (
    output I_En, I_RW, A_Addr, B_Addr, O_En, O_RW, C_Addr, SAD_In,
           Ld_En, Ld_Sel, Ld_Addr, Ld_Data, Rd_En, Rd_Addr,
    input  A_Data, B_Data, Rd_Data, Rd_Valid, Wr_Count, Coll_Err
  );

  modport slave (
    input  I_En, I_RW, A_Addr, B_Addr, O_En, O_RW, C_Addr, SAD_In,
           Ld_En, Ld_Sel, Ld_Addr, Ld_Data, Rd_En, Rd_Addr,
    output A_Data, B_Data, Rd_Data, Rd_Valid, Wr_Count, Coll_Err
  );
endinterface

// File: rtl/sad_mem_resp.sv
// rtl/sad_mem_resp.sv - input byte arrays A/B and result store for the SAD engine
//
// Purpose : two 32 KiB byte arrays read by the SAD engine through a 1- or
//           2-cycle pipeline, preloaded by the host; a C_DEPTH x 32-bit result
//           store written by the engine and read back by the host.
// Ports   : Clk  - sole clock, rising edge
//           Rst  - synchronous, active-low reset
//           bus  - sad_mem_resp_if.slave (see interface file for signal list)
// Params  : RD_LAT  - read latency, 1 or 2
//           C_DEPTH - number of result entries
module sad_mem_resp #(
  parameter int RD_LAT  = 1,
  parameter int C_DEPTH = 128
) (
  input logic          Clk,
  input logic          Rst,
  sad_mem_resp_if.slave bus
);

  localparam bit         TWO_STAGE = (RD_LAT == 2);
  localparam logic [7:0] C_MAX     = 8'(C_DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [7:0]  mem_a [0:32767];
  logic [7:0]  mem_b [0:32767];
  logic [31:0] c_mem [0:C_DEPTH-1];
  logic [C_DEPTH-1:0] c_wr;

  state_t      state, state_nxt;
  logic        req;
  logic        in_flight;
  logic        s1_vld;
  logic [7:0]  s1_a, s1_b;
  logic        c_write;
  logic        coll;

  assign req       = bus.I_En & ~bus.I_RW;
  assign in_flight = TWO_STAGE & s1_vld;
  assign c_write   = bus.O_En & bus.O_RW;

  // A preload and a read hitting the same byte of the same array on one edge.
  assign coll = req & bus.Ld_En &
                ((~bus.Ld_Sel & (bus.Ld_Addr == bus.A_Addr)) |
                 ( bus.Ld_Sel & (bus.Ld_Addr == bus.B_Addr)));

  // Array contents survive reset, so the write ports carry no reset branch;
  // they are merely gated off while Rst is low.
  always_ff @(posedge Clk) begin
    if (Rst && bus.Ld_En) begin
      if (bus.Ld_Sel) mem_b[bus.Ld_Addr] <= bus.Ld_Data;
      else            mem_a[bus.Ld_Addr] <= bus.Ld_Data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst && c_write) c_mem[bus.C_Addr] <= bus.SAD_In;
  end

  // Read pipeline. The arrays are sampled at the request edge itself, which
  // captures the addresses and yields the pre-write byte on a preload clash.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      bus.A_Data <= 8'h00;
      bus.B_Data <= 8'h00;
      s1_vld     <= 1'b0;
      s1_a       <= 8'h00;
      s1_b       <= 8'h00;
      state      <= IDLE;
    end else begin
      state <= state_nxt;
      if (TWO_STAGE) begin
        s1_vld <= req;
        if (req) begin
          s1_a <= mem_a[bus.A_Addr];
          s1_b <= mem_b[bus.B_Addr];
        end
        if (state == BUSY && s1_vld) begin
          bus.A_Data <= s1_a;
          bus.B_Data <= s1_b;
        end
      end else if (req) begin
        bus.A_Data <= mem_a[bus.A_Addr];
        bus.B_Data <= mem_b[bus.B_Addr];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = BUSY;
      BUSY:    if (!req && !in_flight) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result bookkeeping and host readback. Readback samples c_wr/c_mem before
  // this edge's write lands, giving the pre-write value on a same-entry clash.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      c_wr         <= '0;
      bus.Wr_Count <= 8'd0;
      bus.Rd_Data  <= 32'd0;
      bus.Rd_Valid <= 1'b0;
      bus.Coll_Err <= 1'b0;
    end else begin
      if (coll) bus.Coll_Err <= 1'b1;
      if (c_write) begin
        c_wr[bus.C_Addr] <= 1'b1;
        if (!c_wr[bus.C_Addr] && bus.Wr_Count < C_MAX)
          bus.Wr_Count <= bus.Wr_Count + 8'd1;
      end
      bus.Rd_Valid <= bus.Rd_En;
      if (bus.Rd_En)
        bus.Rd_Data <= c_wr[bus.Rd_Addr] ? c_mem[bus.Rd_Addr] : 32'd0;
    end
  end

endmodule

// File: tb/tb_sad_mem_resp.sv
// tb/tb_sad_mem_resp.sv - directed self-checking bench for sad_mem_resp, RD_LAT 1 and 2
//
// Purpose : drives one stimulus stream into two instances (RD_LAT=1 and
//           RD_LAT=2) and checks each against hand-computed values.
// Ports   : none (top-level bench).
module tb_sad_mem_resp;
  logic Clk = 1'b0;
  logic Rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 Clk = ~Clk;

  sad_mem_resp_if bus1 ();
  sad_mem_resp_if bus2 ();

  assign bus2.I_En    = bus1.I_En;
  assign bus2.I_RW    = bus1.I_RW;
  assign bus2.A_Addr  = bus1.A_Addr;
  assign bus2.B_Addr  = bus1.B_Addr;
  assign bus2.O_En    = bus1.O_En;
  assign bus2.O_RW    = bus1.O_RW;
  assign bus2.C_Addr  = bus1.C_Addr;
  assign bus2.SAD_In  = bus1.SAD_In;
  assign bus2.Ld_En   = bus1.Ld_En;
  assign bus2.Ld_Sel  = bus1.Ld_Sel;
  assign bus2.Ld_Addr = bus1.Ld_Addr;
  assign bus2.Ld_Data = bus1.Ld_Data;
  assign bus2.Rd_En   = bus1.Rd_En;
  assign bus2.Rd_Addr = bus1.Rd_Addr;

  sad_mem_resp #(.RD_LAT(1), .C_DEPTH(128)) dut1 (.Clk(Clk), .Rst(Rst), .bus(bus1.slave));
  sad_mem_resp #(.RD_LAT(2), .C_DEPTH(128)) dut2 (.Clk(Clk), .Rst(Rst), .bus(bus2.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus1.I_En = 0; bus1.I_RW = 0; bus1.A_Addr = 0; bus1.B_Addr = 0;
    bus1.O_En = 0; bus1.O_RW = 0; bus1.C_Addr = 0; bus1.SAD_In = 0;
    bus1.Ld_En = 0; bus1.Ld_Sel = 0; bus1.Ld_Addr = 0; bus1.Ld_Data = 0;
    bus1.Rd_En = 0; bus1.Rd_Addr = 0;
  endtask

  task automatic preload(input logic sel, input logic [14:0] addr, input logic [7:0] data);
    bus1.Ld_En = 1; bus1.Ld_Sel = sel; bus1.Ld_Addr = addr; bus1.Ld_Data = data;
    step();
    bus1.Ld_En = 0;
  endtask

  task automatic wr_res(input logic [6:0] idx, input logic [31:0] data);
    bus1.O_En = 1; bus1.O_RW = 1; bus1.C_Addr = idx; bus1.SAD_In = data;
    step();
    bus1.O_En = 0; bus1.O_RW = 0;
  endtask

  task automatic readback(input logic [6:0] idx, input logic [31:0] exp, input string tag);
    bus1.Rd_En = 1; bus1.Rd_Addr = idx;
    step();
    bus1.Rd_En = 0;
    chk({tag, "_valid"}, {31'd0, bus1.Rd_Valid}, 32'd1);
    chk({tag, "_data"}, bus1.Rd_Data, exp);
    step();
    chk({tag, "_valid_drop"}, {31'd0, bus1.Rd_Valid}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    Rst = 0;
    step(); step();
    chk("rst_a1", {24'd0, bus1.A_Data}, 32'd0);
    chk("rst_b2", {24'd0, bus2.B_Data}, 32'd0);
    chk("rst_cnt", {24'd0, bus1.Wr_Count}, 32'd0);
    chk("rst_coll", {31'd0, bus1.Coll_Err}, 32'd0);
    chk("rst_rdv", {31'd0, bus1.Rd_Valid}, 32'd0);
    chk("rst_rdd", bus2.Rd_Data, 32'd0);
    Rst = 1;
    step();

    // Basic read, held through idle cycles.
    preload(0, 15'd5, 8'h3C);
    preload(1, 15'd5, 8'h10);
    bus1.I_En = 1; bus1.A_Addr = 5; bus1.B_Addr = 5;
    step();
    bus1.I_En = 0;
    chk("rd5_l1_a", {24'd0, bus1.A_Data}, 32'h3C);
    chk("rd5_l1_b", {24'd0, bus1.B_Data}, 32'h10);
    chk("rd5_l2_early", {24'd0, bus2.A_Data}, 32'h00);
    step();
    chk("rd5_l2_a", {24'd0, bus2.A_Data}, 32'h3C);
    chk("rd5_l2_b", {24'd0, bus2.B_Data}, 32'h10);
    step(); step(); step();
    chk("rd5_hold_l1", {24'd0, bus1.A_Data}, 32'h3C);
    chk("rd5_hold_l2", {24'd0, bus2.B_Data}, 32'h10);

    // 256 back-to-back reads.
    for (int n = 0; n < 256; n++) preload(0, 15'(n), 8'(n));
    for (int n = 0; n < 256; n++) preload(1, 15'(n), 8'(255 - n));
    for (int n = 0; n < 256; n++) begin
      bus1.I_En = 1; bus1.A_Addr = 15'(n); bus1.B_Addr = 15'(n);
      step();
      chk("burst_l1_a", {24'd0, bus1.A_Data}, 32'(n));
      chk("burst_l1_b", {24'd0, bus1.B_Data}, 32'(255 - n));
      if (n > 0) begin
        chk("burst_l2_a", {24'd0, bus2.A_Data}, 32'(n - 1));
        chk("burst_l2_b", {24'd0, bus2.B_Data}, 32'(256 - n));
      end
    end
    bus1.I_En = 0;
    step();
    chk("burst_l2_last_a", {24'd0, bus2.A_Data}, 32'd255);
    chk("burst_l2_last_b", {24'd0, bus2.B_Data}, 32'd0);

    // Write requests on the read port are ignored.
    bus1.I_En = 1; bus1.I_RW = 1; bus1.A_Addr = 9; bus1.B_Addr = 9;
    step();
    bus1.I_En = 0; bus1.I_RW = 0;
    step();
    chk("irw_ign_l1", {24'd0, bus1.A_Data}, 32'd255);
    chk("irw_ign_l2", {24'd0, bus2.A_Data}, 32'd255);

    // Same-edge preload/read collision.
    preload(0, 15'd7, 8'h11);
    chk("coll_pre", {31'd0, bus1.Coll_Err}, 32'd0);
    bus1.Ld_En = 1; bus1.Ld_Sel = 0; bus1.Ld_Addr = 7; bus1.Ld_Data = 8'hAA;
    bus1.I_En = 1; bus1.A_Addr = 7; bus1.B_Addr = 7;
    step();
    bus1.Ld_En = 0; bus1.I_En = 0;
    chk("coll_l1_old", {24'd0, bus1.A_Data}, 32'h11);
    chk("coll_flag1", {31'd0, bus1.Coll_Err}, 32'd1);
    step();
    chk("coll_l2_old", {24'd0, bus2.A_Data}, 32'h11);
    chk("coll_l2_b", {24'd0, bus2.B_Data}, 32'd248);
    step(); step();
    chk("coll_sticky1", {31'd0, bus1.Coll_Err}, 32'd1);
    chk("coll_sticky2", {31'd0, bus2.Coll_Err}, 32'd1);
    bus1.I_En = 1; bus1.A_Addr = 7;
    step();
    bus1.I_En = 0;
    chk("coll_new_l1", {24'd0, bus1.A_Data}, 32'hAA);
    step();
    chk("coll_new_l2", {24'd0, bus2.A_Data}, 32'hAA);

    // Result store.
    bus1.O_En = 1; bus1.O_RW = 0; bus1.C_Addr = 5; bus1.SAD_In = 32'hDEAD;
    step();
    bus1.O_En = 0;
    chk("orw0_cnt", {24'd0, bus1.Wr_Count}, 32'd0);
    wr_res(7'd3, 32'h1234);
    wr_res(7'd3, 32'h1234);
    wr_res(7'd127, 32'hFFFFFFFF);
    chk("cnt2", {24'd0, bus1.Wr_Count}, 32'd2);
    readback(7'd3, 32'h1234, "rb3");
    readback(7'd4, 32'h0, "rb4");
    readback(7'd127, 32'hFFFFFFFF, "rb127");
    readback(7'd5, 32'h0, "rb5_noop");
    bus1.O_En = 1; bus1.O_RW = 1; bus1.C_Addr = 4; bus1.SAD_In = 32'hBEEF;
    bus1.Rd_En = 1; bus1.Rd_Addr = 4;
    step();
    bus1.O_En = 0; bus1.O_RW = 0; bus1.Rd_En = 0;
    chk("rbw_same_edge", bus1.Rd_Data, 32'h0);
    chk("cnt3", {24'd0, bus1.Wr_Count}, 32'd3);
    readback(7'd4, 32'hBEEF, "rb4_new");

    // Reset with a read in flight; activity during reset is ignored.
    preload(0, 15'd9, 8'h55);
    bus1.I_En = 1; bus1.A_Addr = 9; bus1.B_Addr = 9;
    step();
    bus1.I_En = 0;
    Rst = 0;
    bus1.Ld_En = 1; bus1.Ld_Sel = 0; bus1.Ld_Addr = 9; bus1.Ld_Data = 8'h77;
    bus1.O_En = 1; bus1.O_RW = 1; bus1.C_Addr = 10; bus1.SAD_In = 32'h99;
    step();
    chk("rstf_a1", {24'd0, bus1.A_Data}, 32'd0);
    chk("rstf_a2", {24'd0, bus2.A_Data}, 32'd0);
    chk("rstf_cnt", {24'd0, bus1.Wr_Count}, 32'd0);
    chk("rstf_coll", {31'd0, bus2.Coll_Err}, 32'd0);
    step();
    idle_inputs();
    Rst = 1;
    step(); step();
    chk("rstf_nostale", {24'd0, bus2.A_Data}, 32'd0);
    chk("rstf_cnt_hold", {24'd0, bus2.Wr_Count}, 32'd0);
    readback(7'd3, 32'h0, "rb3_after_rst");
    bus1.I_En = 1; bus1.A_Addr = 9; bus1.B_Addr = 5;
    step();
    bus1.I_En = 0;
    chk("post_rst_l1", {24'd0, bus1.A_Data}, 32'h55);
    chk("post_rst_l1_b", {24'd0, bus1.B_Data}, 32'd250);
    step();
    chk("post_rst_l2", {24'd0, bus2.A_Data}, 32'h55);

    // Fill the store, then rewrite entry 0: count saturates at 128.
    for (int i = 0; i < 128; i++) wr_res(7'(i), 32'(i) + 32'h100);
    chk("cnt_full", {24'd0, bus1.Wr_Count}, 32'd128);
    wr_res(7'd0, 32'hCAFE);
    chk("cnt_nowrap1", {24'd0, bus1.Wr_Count}, 32'd128);
    chk("cnt_nowrap2", {24'd0, bus2.Wr_Count}, 32'd128);
    readback(7'd0, 32'hCAFE, "rb0_rew");
    readback(7'd77, 32'h14D, "rb77");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
